// File: rtl/fdiv_iter.sv
// Iterative single-precision divider, truncating, restoring division on 24-bit significands.
// Denormals treated as zero; fixed latency for every operand class.
module fdiv_iter #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic        unf,
  output logic        dz
);

  localparam int ITER = 25 / BITS_PER_CYCLE;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [CW-1:0] cnt;
  logic          s;
  logic [7:0]    e1;
  logic [7:0]    e2;
  logic [23:0]   m2;
  logic [25:0]   rem;
  logic [24:0]   quo;
  logic [25:0]   rem_nx;
  logic [24:0]   quo_nx;

  logic          accept;
  logic          last;

  logic signed [9:0] ye0;
  logic [22:0]       ym;
  logic [31:0]       y_nx;
  logic              ovf_nx;
  logic              unf_nx;
  logic              dz_nx;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (state == DIV) && (cnt == CW'(ITER));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = DIV;
      DIV:     if (last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // BITS_PER_CYCLE restoring steps chained combinationally
  always_comb begin
    rem_nx = rem;
    quo_nx = quo;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (rem_nx >= {2'b00, m2}) begin
        rem_nx = rem_nx - {2'b00, m2};
        quo_nx = {quo_nx[23:0], 1'b1};
      end else begin
        quo_nx = {quo_nx[23:0], 1'b0};
      end
      rem_nx = {rem_nx[24:0], 1'b0};
    end
  end

  always_comb begin
    ym  = quo[24] ? quo[23:1] : quo[22:0];
    ye0 = $signed({2'b00, e1}) - $signed({2'b00, e2})
        + (quo[24] ? 10'sd127 : 10'sd126);
    y_nx   = {s, ye0[7:0], ym};
    ovf_nx = 1'b0;
    unf_nx = 1'b0;
    dz_nx  = 1'b0;
    if (e2 == 8'h00) begin
      y_nx  = {s, 8'hFF, 23'b0};
      dz_nx = 1'b1;
    end else if (e1 == 8'hFF) begin
      y_nx = {s, 8'hFF, 23'b0};
    end else if (e1 == 8'h00) begin
      y_nx = {s, 31'b0};
    end else if (e2 == 8'hFF) begin
      y_nx = {s, 31'b0};
    end else if (ye0 >= 10'sd255) begin
      y_nx   = {s, 8'hFF, 23'b0};
      ovf_nx = 1'b1;
    end else if (ye0 <= 10'sd0) begin
      y_nx   = {s, 31'b0};
      unf_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      s   <= 1'b0;
      e1  <= '0;
      e2  <= '0;
      m2  <= '0;
      rem <= '0;
      quo <= '0;
      y   <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      dz  <= 1'b0;
    end else begin
      if (accept) begin
        s   <= x1[31] ^ x2[31];
        e1  <= x1[30:23];
        e2  <= x2[30:23];
        m2  <= {1'b1, x2[22:0]};
        rem <= {3'b001, x1[22:0]};
        quo <= '0;
        cnt <= '0;
      end else if (state == DIV && !last) begin
        rem <= rem_nx;
        quo <= quo_nx;
        cnt <= cnt + 1'b1;
      end
      if (last) begin
        y   <= y_nx;
        ovf <= ovf_nx;
        unf <= unf_nx;
        dz  <= dz_nx;
      end else if (state == DONE && out_ready) begin
        y   <= '0;
        ovf <= 1'b0;
        unf <= 1'b0;
        dz  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fdiv_iter.sv
// Scoreboard bench for fdiv_iter, exercising BITS_PER_CYCLE=1 and 5.
module tb_fdiv_iter;

  typedef struct {
    logic [31:0] y;
    logic        ovf;
    logic        unf;
    logic        dz;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] x1 = '0;
  logic [31:0] x2 = '0;

  logic        ir0, ov0, o0, u0, d0;
  logic        ir1, ov1, o1, u1, d1;
  logic [31:0] y0, y1;

  logic        in_ready, out_valid, ovf, unf, dz;
  logic [31:0] y;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   tmo_cnt = 0;
  int   tmo_seen = 0;
  int   rmode = 0;
  int   iter;
  exp_t sbq[$];
  bit   seen = 0;
  bit   popped = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fdiv_iter #(.BITS_PER_CYCLE(1)) u_b1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid && !sel), .in_ready(ir0),
    .x1(x1), .x2(x2),
    .out_valid(ov0), .out_ready(out_ready && !sel),
    .y(y0), .ovf(o0), .unf(u0), .dz(d0)
  );

  fdiv_iter #(.BITS_PER_CYCLE(5)) u_b5 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid && sel), .in_ready(ir1),
    .x1(x1), .x2(x2),
    .out_valid(ov1), .out_ready(out_ready && sel),
    .y(y1), .ovf(o1), .unf(u1), .dz(d1)
  );

  assign in_ready  = sel ? ir1 : ir0;
  assign out_valid = sel ? ov1 : ov0;
  assign y         = sel ? y1  : y0;
  assign ovf       = sel ? o1  : o0;
  assign unf       = sel ? u1  : u0;
  assign dz        = sel ? d1  : d0;
  assign iter      = sel ? 5 : 25;

  function automatic exp_t mk(input logic [31:0] yy, input logic o,
                              input logic u, input logic d);
    exp_t r;
    r.y = yy; r.ovf = o; r.unf = u; r.dz = d; r.acc = 0;
    return r;
  endfunction

  // Reference: exact integer quotient of significands, then IEEE packing
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   r;
    logic   sg;
    int     ea, eb, e;
    longint ma, mb, q;
    logic [22:0] mant;
    logic [31:0] ev;
    r  = mk(32'h0, 1'b0, 1'b0, 1'b0);
    sg = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (eb == 0) begin
      r.y = {sg, 8'hFF, 23'b0}; r.dz = 1'b1;
    end else if (ea == 255) begin
      r.y = {sg, 8'hFF, 23'b0};
    end else if (ea == 0 || eb == 255) begin
      r.y = {sg, 31'b0};
    end else begin
      ma = longint'({1'b1, a[22:0]});
      mb = longint'({1'b1, b[22:0]});
      q  = (ma * 64'sd16777216) / mb;
      if (q >= 64'sd16777216) begin
        e = ea - eb + 127; mant = 23'((q / 2) % 64'sd8388608);
      end else begin
        e = ea - eb + 126; mant = 23'(q % 64'sd8388608);
      end
      ev = e;
      if (e >= 255) begin
        r.y = {sg, 8'hFF, 23'b0}; r.ovf = 1'b1;
      end else if (e <= 0) begin
        r.y = {sg, 31'b0}; r.unf = 1'b1;
      end else begin
        r.y = {sg, ev[7:0], mant};
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: r[30:23] = 8'h00;
      1: r[30:23] = 8'hFF;
      2: r[30:23] = 8'($urandom_range(1, 10));
      3: r[30:23] = 8'($urandom_range(245, 254));
      4: r[22:0]  = '0;
      default: r[30:23] = 8'($urandom_range(100, 154));
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    #1;
    case (rmode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cyc %0d sel %0d)",
               nm, act, req, cyc, sel);
    end
  endtask

  // Monitor: sole owner of the check counters and scoreboard pops
  always @(negedge clk) begin
    if (tmo_cnt != tmo_seen) begin
      checks++;
      failures++;
      $display("FAIL timeout actual=%0d required=%0d", tmo_cnt, tmo_seen);
      tmo_seen = tmo_cnt;
    end
    if (rst) begin
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_y", y, 32'h0);
      chk("rst_flags", {29'b0, ovf, unf, dz}, 32'h0);
      sbq.delete();
      seen   = 0;
      popped = 0;
    end else begin
      if (popped) begin
        chk("idle_out_valid", {31'b0, out_valid}, 32'd0);
        chk("idle_in_ready", {31'b0, in_ready}, 32'd1);
        chk("idle_y", y, 32'h0);
        chk("idle_flags", {29'b0, ovf, unf, dz}, 32'h0);
        popped = 0;
      end
      if (out_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out_valid", {31'b0, out_valid}, 32'd0);
        end else begin
          if (!seen) begin
            chk("latency", cyc - sbq[0].acc, iter + 1);
            seen = 1;
          end
          chk("y", y, sbq[0].y);
          chk("flags", {29'b0, ovf, unf, dz},
              {29'b0, sbq[0].ovf, sbq[0].unf, sbq[0].dz});
          chk("done_in_ready", {31'b0, in_ready}, 32'd0);
          if (out_ready) begin
            void'(sbq.pop_front());
            seen   = 0;
            popped = 1;
          end
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input exp_t e);
    int n = 0;
    exp_t ee = e;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tmo_cnt++;
      return;
    end
    x1 = a;
    x2 = b;
    in_valid = 1'b1;
    @(negedge clk);
    ee.acc = cyc;
    sbq.push_back(ee);
    in_valid = 1'b0;
    x1 = $urandom;
    x2 = $urandom;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      tmo_cnt++;
      do_reset();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    int n;
    for (int c = 0; c < 2; c++) begin
      rmode = 0;
      sel = (c == 1);
      do_reset();
      issue(32'h40C00000, 32'h40000000, mk(32'h40400000, 0, 0, 0));
      issue(32'h3F800000, 32'h40400000, mk(32'h3EAAAAAA, 0, 0, 0));
      issue(32'hC0000000, 32'h3F000000, mk(32'hC0800000, 0, 0, 0));
      issue(32'h3F800000, 32'h00000000, mk(32'h7F800000, 0, 0, 1));
      issue(32'h00000000, 32'h3F800000, mk(32'h00000000, 0, 0, 0));
      issue(32'h80000000, 32'h7F800000, mk(32'h80000000, 0, 0, 0));
      issue(32'h7F000000, 32'h00800000, mk(32'h7F800000, 1, 0, 0));
      issue(32'h00800000, 32'h7F000000, mk(32'h00000000, 0, 1, 0));
      issue(32'h00000000, 32'h00000000, mk(32'h7F800000, 0, 0, 1));
      issue(32'hFF800000, 32'h3F800000, mk(32'hFF800000, 0, 0, 0));
      drain();

      // result held while consumer stalls; new requests ignored
      rmode = 2;
      issue(32'h40C00000, 32'h40000000, mk(32'h40400000, 0, 0, 0));
      n = 0;
      while (!out_valid && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!out_valid) tmo_cnt++;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        in_valid = k[0];
        x1 = 32'h3F800000;
        x2 = 32'h40400000;
      end
      @(negedge clk);
      in_valid = 1'b0;
      rmode = 0;
      drain();

      // reset while dividing
      issue(32'h3F800000, 32'h40400000, mk(32'h3EAAAAAA, 0, 0, 0));
      repeat (sel ? 2 : 9) @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      issue(32'h40C00000, 32'h40000000, mk(32'h40400000, 0, 0, 0));
      drain();

      rmode = 1;
      for (int k = 0; k < 60; k++) begin
        a = rnd_op();
        b = rnd_op();
        issue(a, b, model(a, b));
      end
      drain();
      rmode = 0;
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
